// File: rtl/instruction_memory_loader_pkg.sv
// -----------------------------------------------------------------------------
// instruction_memory_loader_pkg
// Shared CPU package for the boot-time instruction loader: the loader FSM state
// encoding, the default values of the loader parameters, and the widths used
// on the loader's byte and memory-write interfaces.
// -----------------------------------------------------------------------------
package instruction_memory_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } loader_state_t;

  localparam int unsigned DEF_MAX_WORDS      = 64;
  localparam int unsigned DEF_ADDR_STEP      = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1023;

  localparam int BYTE_W  = 8;
  localparam int WORD_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int COUNT_W = 8;

  // States in which a start request is honoured.
  function automatic logic accepts_start(loader_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/instruction_memory_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// instruction_memory_loader_word_assembler
// Shifts program bytes into a 32-bit word, big-endian (first byte lands in
// bits 31:24), and counts bytes with a 2-bit counter.
//
// Ports
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   load     : byte_in is accepted on this edge
//   clear    : drop the partial word and restart at byte 0 (wins over load)
//   byte_in  : program byte
//   word     : assembled word (valid once the 4th byte has been loaded)
//   full     : this load completes the word (4th byte of the word)
// -----------------------------------------------------------------------------
module instruction_memory_loader_word_assembler
  import instruction_memory_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  logic [1:0] byte_cnt;

  // Combinational so the controller can leave COLLECT on the same edge that
  // takes the 4th byte; the word is then stable during the write cycle.
  assign full = load && (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= 2'd0;
      word     <= '0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      word     <= '0;
    end else if (load) begin
      word     <= {word[WORD_W-BYTE_W-1:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instruction_memory_loader.sv
// -----------------------------------------------------------------------------
// instruction_memory_loader
// Receives a program as a byte stream, packs it into 32-bit big-endian words
// and writes them to consecutive instruction-memory addresses starting at 0,
// holding the CPU in reset until the whole program is in place.
//
// Ports
//   clk             : clock, rising edge
//   reset           : asynchronous active-low reset
//   start           : begin a load (honoured in IDLE, DONE, ERROR)
//   word_count      : words to load, sampled with an accepted start
//   byte_in         : program byte
//   byte_valid      : byte_in is valid
//   byte_ready      : loader accepts a byte (COLLECT only)
//   imem_write_en   : one-cycle write strobe
//   imem_write_addr : byte address of the word being written
//   imem_write_data : assembled instruction word
//   cpu_hold        : hold CPU in reset (low only in DONE)
//   busy            : COLLECT or WRITE
//   done            : load finished
//   error           : bad word_count or inter-byte timeout
// -----------------------------------------------------------------------------
module instruction_memory_loader
  import instruction_memory_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS      = DEF_MAX_WORDS,
  parameter int unsigned ADDR_STEP      = DEF_ADDR_STEP,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] word_count,
  input  logic [BYTE_W-1:0]  byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               imem_write_en,
  output logic [ADDR_W-1:0]  imem_write_addr,
  output logic [WORD_W-1:0]  imem_write_data,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_t      state, state_nxt;
  logic [COUNT_W-1:0] wc_q;
  logic [COUNT_W-1:0] words_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [TMO_W-1:0]   tmo_q;

  logic               transfer;
  logic               accept;
  logic               asm_clear;
  logic               word_full;
  logic               tmo_hit;
  logic               last_word;
  logic               wc_too_big;
  logic [WORD_W-1:0]  asm_word;

  assign transfer   = byte_valid && byte_ready;
  assign wc_too_big = (32'(word_count) > MAX_WORDS);
  assign last_word  = ((words_q + 8'd1) == wc_q);
  // The counter holds the idle cycles seen so far; the idle cycle that would
  // bring it to TIMEOUT_CYCLES is the one that aborts the load.
  assign tmo_hit    = (state == ST_COLLECT) && !transfer &&
                      (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  instruction_memory_loader_word_assembler word_assembler (
    .clk     (clk),
    .reset   (reset),
    .load    (transfer),
    .clear   (asm_clear),
    .byte_in (byte_in),
    .word    (asm_word),
    .full    (word_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    asm_clear     = 1'b0;
    byte_ready    = 1'b0;
    imem_write_en = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    cpu_hold      = 1'b1;

    case (state)
      ST_COLLECT: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (word_full) begin
          state_nxt = ST_WRITE;
        end else if (tmo_hit) begin
          state_nxt = ST_ERROR;
          asm_clear = 1'b1;
        end
      end
      ST_WRITE: begin
        imem_write_en = 1'b1;
        busy          = 1'b1;
        state_nxt     = last_word ? ST_DONE : ST_COLLECT;
      end
      default: begin
        done     = (state == ST_DONE);
        error    = (state == ST_ERROR);
        cpu_hold = (state != ST_DONE);
        if (start && accepts_start(state)) begin
          accept    = 1'b1;
          asm_clear = 1'b1;
          if (word_count == '0) begin
            state_nxt = ST_DONE;
          end else if (wc_too_big) begin
            state_nxt = ST_ERROR;
          end else begin
            state_nxt = ST_COLLECT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wc_q    <= '0;
      words_q <= '0;
      addr_q  <= '0;
      tmo_q   <= '0;
    end else begin
      if (accept) begin
        wc_q    <= word_count;
        words_q <= '0;
        addr_q  <= '0;
      end else if (state == ST_WRITE) begin
        words_q <= words_q + 8'd1;
        addr_q  <= addr_q + ADDR_STEP;
      end

      if ((state == ST_COLLECT) && !transfer) begin
        tmo_q <= tmo_q + 1'b1;
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign imem_write_addr = addr_q;
  assign imem_write_data = asm_word;

endmodule

// File: tb/tb_instruction_memory_loader.sv
module tb_instruction_memory_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  word_count = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        imem_write_en;
  logic [31:0] imem_write_addr;
  logic [31:0] imem_write_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  wcyc[$];
  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;
  int  nwrites = 0;

  instruction_memory_loader dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .word_count      (word_count),
    .byte_in         (byte_in),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .imem_write_en   (imem_write_en),
    .imem_write_addr (imem_write_addr),
    .imem_write_data (imem_write_data),
    .cpu_hold        (cpu_hold),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe pops the oldest expected write.
  always @(negedge clk) begin
    if (imem_write_en === 1'b1) begin
      nwrites++;
      wcyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'd0, imem_write_en}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", imem_write_addr, e.addr);
        check("write_data", imem_write_data, e.data);
        check("ready_in_write", {31'd0, byte_ready}, 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [7:0] wc);
    start = 1'b1;
    word_count = wc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r;
    logic ok;
    ok = 1'b0;
    byte_in = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r = byte_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    byte_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) begin
      if (maxgap > 0) tick($urandom_range(maxgap, 0));
      send_byte(w[31-8*i -: 8]);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_wen"},   {31'd0, imem_write_en}, 32'd0);
    check({tag, "_addr"},  imem_write_addr, 32'd0);
    check({tag, "_data"},  imem_write_data, 32'd0);
    check({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w3 [3];
    logic [31:0] rw;
    int          n0;
    w3[0] = 32'h11223344;
    w3[1] = 32'hA5A55A5A;
    w3[2] = 32'hDEADBEEF;

    // Reset state
    tick(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    tick(2);
    check("idle_hold", {31'd0, cpu_hold}, 32'd1);
    check("idle_ready", {31'd0, byte_ready}, 32'd0);

    // Single word, back-to-back bytes
    push(32'h0, 32'h8B1F03E0);
    do_start(8'd1);
    check("w1_busy", {31'd0, busy}, 32'd1);
    check("w1_ready", {31'd0, byte_ready}, 32'd1);
    send_word(32'h8B1F03E0, 0);
    tick(2);
    check("w1_done", {31'd0, done}, 32'd1);
    check("w1_hold", {31'd0, cpu_hold}, 32'd0);
    check("w1_busy_end", {31'd0, busy}, 32'd0);
    check("w1_pending", 32'(exp_q.size()), 32'd0);

    // Three words, continuous bytes, strobes 5 cycles apart
    wcyc.delete();
    for (int i = 0; i < 3; i++) push(32'(4 * i), w3[i]);
    do_start(8'd3);
    for (int i = 0; i < 3; i++) send_word(w3[i], 0);
    tick(2);
    check("w3_count", 32'(wcyc.size()), 32'd3);
    if (wcyc.size() == 3) begin
      check("w3_space01", 32'(wcyc[1] - wcyc[0]), 32'd5);
      check("w3_space12", 32'(wcyc[2] - wcyc[1]), 32'd5);
    end
    check("w3_done", {31'd0, done}, 32'd1);
    check("w3_pending", 32'(exp_q.size()), 32'd0);

    // word_count above MAX_WORDS, then zero
    n0 = nwrites;
    do_start(8'd65);
    check("wc65_error", {31'd0, error}, 32'd1);
    check("wc65_hold", {31'd0, cpu_hold}, 32'd1);
    check("wc65_done", {31'd0, done}, 32'd0);
    do_start(8'd0);
    check("wc0_done", {31'd0, done}, 32'd1);
    check("wc0_error", {31'd0, error}, 32'd0);
    tick(2);
    check("wc_nowrite", 32'(nwrites - n0), 32'd0);

    // MAX_WORDS words with random gaps; start in COLLECT is ignored
    do_start(8'd64);
    check("wc64_busy", {31'd0, busy}, 32'd1);
    check("wc64_error", {31'd0, error}, 32'd0);
    do_start(8'd0);
    check("ign_start_busy", {31'd0, busy}, 32'd1);
    check("ign_start_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      rw = $urandom;
      push(32'(4 * i), rw);
      send_word(rw, 2);
    end
    tick(2);
    check("wc64_done", {31'd0, done}, 32'd1);
    check("wc64_pending", 32'(exp_q.size()), 32'd0);

    // Same three words with random gaps below the timeout
    for (int i = 0; i < 3; i++) push(32'(4 * i), w3[i]);
    do_start(8'd3);
    for (int i = 0; i < 3; i++) send_word(w3[i], 6);
    tick(2);
    check("gap_done", {31'd0, done}, 32'd1);
    check("gap_pending", 32'(exp_q.size()), 32'd0);

    // Inter-byte timeout after two bytes, then recovery
    n0 = nwrites;
    do_start(8'd1);
    send_byte(8'hCA);
    send_byte(8'hFE);
    tick(1022);
    check("tmo_before_busy", {31'd0, busy}, 32'd1);
    check("tmo_before_error", {31'd0, error}, 32'd0);
    tick(1);
    check("tmo_error", {31'd0, error}, 32'd1);
    check("tmo_hold", {31'd0, cpu_hold}, 32'd1);
    check("tmo_ready", {31'd0, byte_ready}, 32'd0);
    check("tmo_nowrite", 32'(nwrites - n0), 32'd0);
    push(32'h0, 32'h01020304);
    do_start(8'd1);
    send_word(32'h01020304, 0);
    tick(2);
    check("tmo_recover_done", {31'd0, done}, 32'd1);
    check("tmo_recover_pending", 32'(exp_q.size()), 32'd0);

    // Reset after the 3rd byte of word 2
    push(32'h0, 32'hCAFEF00D);
    do_start(8'd2);
    send_word(32'hCAFEF00D, 0);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    n0 = nwrites;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick(4);
    check("midreset_nowrite", 32'(nwrites - n0), 32'd0);
    check("midreset_pending", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    tick(1);
    push(32'h0, 32'h0BADBEEF);
    do_start(8'd1);
    send_word(32'h0BADBEEF, 0);
    tick(2);
    check("post_reset_done", {31'd0, done}, 32'd1);
    check("post_reset_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
